// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN pipeline scheduler and its helpers.
package cnn_pkg;
  typedef enum logic [2:0] {IDLE, L0, L1, L2, TX, ERR} sched_state_t;

  localparam int TIMEOUT_DEF = 1048576;
  localparam int CNT_W_DEF   = 8;
endpackage

// File: rtl/cnn_sched_if.sv
// Host/layer signal bundle for cnn_sched; the master side drives events, the slave side is the scheduler.
interface cnn_sched_if import cnn_pkg::*; #(parameter int CNT_W = 8);
  // Handshake: every event and start signal is a single-cycle pulse sampled on the rising
  // edge; there is no backpressure, so a pulse seen outside its wait state is simply dropped.
  logic             strt;
  logic             tx_done;
  logic             rdy_l0;
  logic             rdy_l1;
  logic             res_vld;
  logic             strt_l0;
  logic             strt_l1;
  logic             strt_l2;
  logic             trmt;
  logic             bsy;
  logic             err;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
  sched_state_t     state;

  modport master (
    output strt, tx_done, rdy_l0, rdy_l1, res_vld,
    input  strt_l0, strt_l1, strt_l2, trmt, bsy, err, frame_cnt, err_cnt, state
  );

  modport slave (
    input  strt, tx_done, rdy_l0, rdy_l1, res_vld,
    output strt_l0, strt_l1, strt_l2, trmt, bsy, err, frame_cnt, err_cnt, state
  );
endinterface

// File: rtl/cnn_wdog.sv
// Stall watchdog: counts enabled cycles after a clear and flags the last allowed cycle.
module cnn_wdog #(
  parameter int TIMEOUT = 1048576
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  // Holds at LAST so the counter can never wrap back to a fresh budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expire = en && (cnt_q == LAST);
endmodule

// File: rtl/cnn_sched.sv
// Frame sequencer for the conv / max-pool / conv pipeline: issues per-layer start pulses,
// gates the UART transmit, counts finished frames and aborts stalled ones.
module cnn_sched import cnn_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  cnn_sched_if.slave   bus
);
  sched_state_t     state_q, state_d;
  logic             adv;
  logic             expire;
  logic             wd_en;
  logic             wd_clr;
  logic             strt_l0_q, strt_l1_q, strt_l2_q, trmt_q;
  logic             bsy_q, err_q;
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

  assign wd_en  = (state_q == L0) || (state_q == L1) || (state_q == L2) || (state_q == TX);
  assign wd_clr = (state_d != state_q);

  cnn_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    unique case (state_q)
      IDLE, ERR: if (bus.strt)    state_d = L0;
      L0:        if (bus.rdy_l0)  begin adv = 1'b1; state_d = L1;   end
      L1:        if (bus.rdy_l1)  begin adv = 1'b1; state_d = L2;   end
      L2:        if (bus.res_vld) begin adv = 1'b1; state_d = TX;   end
      TX:        if (bus.tx_done) begin adv = 1'b1; state_d = IDLE; end
      default:   state_d = IDLE;
    endcase
    // A layer event landing on the expiry cycle still counts as progress.
    if (expire && !adv) state_d = ERR;
  end

  // Start pulses fire on state entry, so a pulse can never repeat on back-to-back cycles.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      strt_l0_q   <= 1'b0;
      strt_l1_q   <= 1'b0;
      strt_l2_q   <= 1'b0;
      trmt_q      <= 1'b0;
      bsy_q       <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      strt_l0_q <= (state_d == L0) && (state_q != L0);
      strt_l1_q <= (state_d == L1) && (state_q != L1);
      strt_l2_q <= (state_d == L2) && (state_q != L2);
      trmt_q    <= (state_d == TX) && (state_q != TX);
      bsy_q     <= (state_d == L0) || (state_d == L1) || (state_d == L2) || (state_d == TX);
      err_q     <= (state_d == ERR);
      if ((state_q == TX) && (state_d == IDLE)) begin
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
      if ((state_d == ERR) && (state_q != ERR) && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.strt_l0   = strt_l0_q;
  assign bus.strt_l1   = strt_l1_q;
  assign bus.strt_l2   = strt_l2_q;
  assign bus.trmt      = trmt_q;
  assign bus.bsy       = bsy_q;
  assign bus.err       = err_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_cnn_sched.sv
// Directed bench for cnn_sched: stimulus pushes expected output events, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_cnn_sched;
  import cnn_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 2;
  localparam int EV_W    = 3 + 16 + 2 * CNT_W;

  localparam logic [2:0] K_L0 = 3'd1, K_L1 = 3'd2, K_L2 = 3'd3, K_TX = 3'd4, K_DONE = 3'd5, K_ERR = 3'd6;
  localparam logic [4:0] I_STRT = 5'b10000, I_R0 = 5'b01000, I_R1 = 5'b00100,
                         I_RV = 5'b00010, I_TD = 5'b00001;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cnn_sched_if #(.CNT_W(CNT_W)) bus ();

  cnn_sched #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_f    = 0;
  int exp_e    = 0;
  logic [EV_W-1:0] exp_q[$];

  function automatic logic [EV_W-1:0] mk_ev(input logic [2:0] k, input int c,
                                            input logic [CNT_W-1:0] f, input logic [CNT_W-1:0] e);
    return {k, 16'(c), f, e};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic expect_ev(input logic [2:0] k, input int c);
    exp_q.push_back(mk_ev(k, c, CNT_W'(exp_f), CNT_W'(exp_e)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic fire(input logic [4:0] m, input int c);
    wait_to(c);
    {bus.strt, bus.rdy_l0, bus.rdy_l1, bus.res_vld, bus.tx_done} = m;
    step();
    {bus.strt, bus.rdy_l0, bus.rdy_l1, bus.res_vld, bus.tx_done} = 5'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b1;
    exp_f = 0;
    exp_e = 0;
    @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'(IDLE));
    chk("rst_pulses", {28'd0, bus.strt_l0, bus.strt_l1, bus.strt_l2, bus.trmt}, 32'd0);
    chk("rst_bsy_err", {30'd0, bus.bsy, bus.err}, 32'd0);
    chk("rst_counts", {28'd0, bus.frame_cnt, bus.err_cnt}, 32'd0);
    rst_n = 1'b0;
    step();
  endtask

  task automatic do_frame();
    int c;
    c = cyc;
    expect_ev(K_L0, c + 1);
    fire(I_STRT, c);
    chk("frame_bsy", 32'(bus.bsy), 32'd1);
    chk("frame_err_clear", 32'(bus.err), 32'd0);
    expect_ev(K_L1, c + 3);
    fire(I_R0, c + 2);
    expect_ev(K_L2, c + 5);
    fire(I_R1, c + 4);
    expect_ev(K_TX, c + 7);
    fire(I_RV, c + 6);
    exp_f = (exp_f + 1) % (1 << CNT_W);
    expect_ev(K_DONE, c + 9);
    fire(I_TD, c + 8);
    wait_to(c + 10);
    chk("frame_idle", 32'(bus.state), 32'(IDLE));
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(exp_f));
  endtask

  task automatic do_timeout();
    int c;
    c = cyc;
    expect_ev(K_L0, c + 1);
    fire(I_STRT, c);
    if (exp_e < (1 << CNT_W) - 1) exp_e++;
    expect_ev(K_ERR, c + 1 + TIMEOUT);
    wait_to(c + 2 + TIMEOUT);
    chk("to_state", 32'(bus.state), 32'(ERR));
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_bsy", 32'(bus.bsy), 32'd0);
    chk("to_err_cnt", 32'(bus.err_cnt), 32'(exp_e));
  endtask

  // scoreboard monitor
  logic       prev_bsy = 1'b0;
  logic       prev_err = 1'b0;
  logic [3:0] prev_p   = 4'd0;

  always @(negedge clk) begin
    logic [3:0]      p;
    logic [2:0]      k;
    logic [EV_W-1:0] got, e;
    p = {bus.trmt, bus.strt_l2, bus.strt_l1, bus.strt_l0};
    if (!rst_n) begin
      k = 3'd0;
      if (p != 4'd0) begin
        checks++;
        if (!$onehot(p) || ((p & prev_p) != 4'd0)) begin
          failures++;
          $display("FAIL pulse_shape: got pulses=%b prev=%b required one-hot, non-repeating (cycle %0d)",
                   p, prev_p, cyc);
        end
        k = p[0] ? K_L0 : p[1] ? K_L1 : p[2] ? K_L2 : K_TX;
      end else if (bus.err && !prev_err) begin
        k = K_ERR;
      end else if (!bus.bsy && prev_bsy && !bus.err) begin
        k = K_DONE;
      end
      if (k != 3'd0) begin
        got = mk_ev(k, cyc, bus.frame_cnt, bus.err_cnt);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: got kind=%0d cycle=%0d, none expected", k, cyc);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL event: got kind=%0d cyc=%0d f=%0d e=%0d expected kind=%0d cyc=%0d f=%0d e=%0d",
                     got[EV_W-1 -: 3], got[2*CNT_W +: 16], got[CNT_W +: CNT_W], got[CNT_W-1:0],
                     e[EV_W-1 -: 3], e[2*CNT_W +: 16], e[CNT_W +: CNT_W], e[CNT_W-1:0]);
          end
        end
      end
    end
    prev_p   = p;
    prev_bsy = bus.bsy;
    prev_err = bus.err;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int c;
    {bus.strt, bus.rdy_l0, bus.rdy_l1, bus.res_vld, bus.tx_done} = 5'b0;
    apply_reset();

    // nominal frame with the documented cycle spacing
    c = cyc;
    expect_ev(K_L0, c + 1);
    fire(I_STRT, c);
    chk("nom_bsy_start", 32'(bus.bsy), 32'd1);
    expect_ev(K_L1, c + 6);
    fire(I_R0, c + 5);
    expect_ev(K_L2, c + 10);
    fire(I_R1, c + 9);
    expect_ev(K_TX, c + 13);
    fire(I_RV, c + 12);
    wait_to(c + 15);
    chk("nom_bsy_last", 32'(bus.bsy), 32'd1);
    exp_f = 1;
    expect_ev(K_DONE, c + 16);
    fire(I_TD, c + 15);
    wait_to(c + 17);
    chk("nom_frame_cnt", 32'(bus.frame_cnt), 32'd1);

    // stalled layer 0, then recovery straight from ERR
    do_timeout();
    do_frame();

    // rdy_l0 on the expiry cycle wins over the abort
    c = cyc;
    expect_ev(K_L0, c + 1);
    fire(I_STRT, c);
    expect_ev(K_L1, c + 1 + TIMEOUT);
    fire(I_R0, c + TIMEOUT);
    chk("race_state", 32'(bus.state), 32'(L1));
    chk("race_err", 32'(bus.err), 32'd0);
    expect_ev(K_L2, c + 19);
    fire(I_R1, c + 18);
    expect_ev(K_TX, c + 21);
    fire(I_RV, c + 20);
    exp_f = (exp_f + 1) % (1 << CNT_W);
    expect_ev(K_DONE, c + 23);
    fire(I_TD, c + 22);
    wait_to(c + 24);
    chk("race_err_cnt", 32'(bus.err_cnt), 32'(exp_e));

    // out-of-state and while-busy events must be ignored
    c = cyc;
    expect_ev(K_L0, c + 1);
    fire(I_STRT, c);
    fire(I_R1, c + 2);
    fire(I_RV | I_TD, c + 3);
    chk("spur_l0", 32'(bus.state), 32'(L0));
    expect_ev(K_L1, c + 5);
    fire(I_R0, c + 4);
    fire(I_STRT, c + 6);
    chk("spur_l1", 32'(bus.state), 32'(L1));
    fire(I_TD | I_R0, c + 7);
    expect_ev(K_L2, c + 9);
    fire(I_R1, c + 8);
    fire(I_TD | I_R0 | I_STRT, c + 10);
    chk("spur_l2", 32'(bus.state), 32'(L2));
    expect_ev(K_TX, c + 13);
    fire(I_RV, c + 12);
    exp_f = (exp_f + 1) % (1 << CNT_W);
    expect_ev(K_DONE, c + 15);
    fire(I_STRT | I_TD, c + 14);
    fire(I_RV, c + 16);
    wait_to(c + 18);
    chk("spur_idle", 32'(bus.state), 32'(IDLE));
    chk("spur_frame_cnt", 32'(bus.frame_cnt), 32'(exp_f));

    // asynchronous reset in the middle of layer 2
    c = cyc;
    expect_ev(K_L0, c + 1);
    fire(I_STRT, c);
    expect_ev(K_L1, c + 3);
    fire(I_R0, c + 2);
    expect_ev(K_L2, c + 5);
    fire(I_R1, c + 4);
    wait_to(c + 6);
    chk("pre_rst_state", 32'(bus.state), 32'(L2));
    #2;
    rst_n = 1'b1;
    #1;
    chk("arst_state", 32'(bus.state), 32'(IDLE));
    chk("arst_outs", {26'd0, bus.strt_l0, bus.strt_l1, bus.strt_l2, bus.trmt, bus.bsy, bus.err}, 32'd0);
    chk("arst_counts", {28'd0, bus.frame_cnt, bus.err_cnt}, 32'd0);
    exp_f = 0;
    exp_e = 0;
    #3;
    rst_n = 1'b0;
    step();
    do_frame();

    // frame counter wrap, then error counter saturation
    apply_reset();
    for (int i = 0; i < 5; i++) do_frame();
    for (int i = 0; i < 5; i++) do_timeout();

    wait_to(cyc + 3);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cnn_sched.md
Name: cnn_sched

Overview:
Top-level sequencer for the three-stage CNN pipeline (conv, max-pool, conv), sitting between the host/UART front end and the layer datapaths. It converts a host frame-start into registered one-cycle start pulses for each layer in order and waits for each layer's ready before advancing. It gates the final result transmit against UART completion and counts finished frames. A per-stage watchdog aborts a stalled frame.

Parameters:
TIMEOUT, 1048576, max cycles allowed in any wait state before abort (>=2)
CNT_W, 8, width of frame and error counters

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-high (1 = reset), named per codebase convention
strt  in  1  host frame-start pulse
tx_done  in  1  UART transmit-complete pulse
rdy_l0  in  1  layer 0 done pulse
rdy_l1  in  1  layer 1 done pulse
res_vld  in  1  layer 2 result-valid pulse
strt_l0  out  1  layer 0 start pulse
strt_l1  out  1  layer 1 start pulse
strt_l2  out  1  layer 2 start pulse
trmt  out  1  result-transmit request pulse to UART
bsy  out  1  frame in progress
err  out  1  sticky watchdog-abort flag
frame_cnt  out  CNT_W  completed frames, wraps
err_cnt  out  CNT_W  aborted frames, saturates at all-ones

Behaviour:
- All outputs registered; reset (async, rst_n=1) forces state IDLE, all pulses 0, bsy=0, err=0, counters 0, watchdog 0.
- States: IDLE, L0, L1, L2, TX, ERR.
- IDLE: strt=1 at edge N -> state L0, strt_l0=1 for cycle N+1 only, bsy=1 from N+1, err cleared.
- L0: rdy_l0 -> L1, strt_l1 one-cycle pulse next cycle.
- L1: rdy_l1 -> L2, strt_l2 one-cycle pulse next cycle.
- L2: res_vld -> TX, trmt one-cycle pulse next cycle.
- TX: tx_done -> IDLE, bsy=0 next cycle, frame_cnt+1 (wraps 2^CNT_W-1 -> 0).
- ERR: bsy=0, err=1 held; strt -> L0 exactly as from IDLE (err cleared, strt_l0 pulsed).
- Watchdog: cleared on every state entry; increments each cycle in L0/L1/L2/TX; when it reaches TIMEOUT-1 with no advancing event that cycle -> ERR next cycle, err_cnt+1 (saturating), no pulses issued.
- Advancing event and timeout in same cycle: event wins.
- strt while bsy=1 ignored (no restart, no pulse). strt and tx_done same cycle in TX: complete frame only, strt dropped.
- Out-of-state events (e.g. rdy_l1 in L0, tx_done in L1, res_vld in IDLE) ignored, no state change.
- Pulse outputs never high two consecutive cycles; at most one of strt_l0/strt_l1/strt_l2/trmt high in any cycle.
- Minimum frame latency strt -> bsy low: 5 cycles plus layer/UART delays.
- Reset mid-frame: immediate return to IDLE, pending pulses dropped, counters cleared.
- Watchdog width $clog2(TIMEOUT); no overflow possible since it stops at TIMEOUT-1.

Decomposition:
- Shared package cnn_pkg: sched_state_t enum (IDLE,L0,L1,L2,TX,ERR), default TIMEOUT constant, CNT_W default.
- One sub-module: cnn_wdog (clear, enable, expire at TIMEOUT-1), reused by later layer controllers.
- FSM, pulse registers and counters stay in cnn_sched.

Test Plan:
- Nominal (TIMEOUT=16): strt at cycle 0, rdy_l0@5, rdy_l1@9, res_vld@12, tx_done@15 -> strt_l0@1, strt_l1@6, strt_l2@10, trmt@13, bsy 1 for cycles 1..15, 0 @16, frame_cnt=1.
- Timeout (TIMEOUT=16): strt, never rdy_l0 -> ERR entered 16 cycles after L0 entry, err=1, bsy=0, err_cnt=1; next strt -> err=0, strt_l0 pulse, normal frame completes, frame_cnt=1.
- Race: rdy_l0 on exactly the expiry cycle -> L1 entered, strt_l1 pulsed, err stays 0.
- Spurious: strt during L1, rdy_l1 during L0, tx_done during L2 -> no state change, no extra pulses, frame_cnt unchanged.
- Wrap/saturate (CNT_W=2): 5 good frames -> frame_cnt 1,2,3,0,1; 5 timeouts -> err_cnt 1,2,3,3,3.
- Async reset asserted mid-L2 between clock edges -> outputs zero before next edge, state IDLE, next strt starts a clean frame.
